// File: rtl/wb_result_sel.sv
`default_nettype none
// ============================================================================
//  Module      : wb_result_sel
//  Description : Write-back result selector. Picks one of NUM_SRC result
//                sources, aligns and extends load data on the memory source,
//                flags illegal beats and registers the result behind a
//                2-entry valid/ready skid buffer.
//  Revision    : 1.0  - initial release
// ============================================================================
module wb_result_sel #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 3,
  parameter int MEM_IDX = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [2:0]              funct3,
  input  logic [1:0]              addr_lo,
  input  logic [4:0]              rd_in,
  input  logic                    we_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [4:0]              out_rd,
  output logic                    out_we,
  output logic                    err
);

  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;

  // Stored beat layout: {data, rd, we, err}
  localparam int BEAT_W = XLEN + 7;

  logic [XLEN-1:0]   w_sel_data;
  logic              w_sel_hit;
  logic              w_is_mem;
  logic [XLEN-1:0]   w_mem_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_data;
  logic              w_load_err;
  logic              w_err;
  logic              w_we;
  logic [XLEN-1:0]   w_res_data;
  logic [BEAT_W-1:0] w_beat;
  logic              w_accept;

  logic [BEAT_W-1:0] main_q, main_d;
  logic              main_valid_q, main_valid_d;
  logic [BEAT_W-1:0] skid_q, skid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;

  // Source mux; a select with no matching source is an illegal beat
  always_comb begin
    w_sel_data = '0;
    w_sel_hit  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_data = src_data[k*XLEN +: XLEN];
        w_sel_hit  = 1'b1;
      end
    end
  end

  assign w_is_mem   = (sel == SEL_W'(MEM_IDX));
  assign w_mem_word = src_data[MEM_IDX*XLEN +: XLEN];
  assign w_byte     = w_mem_word[{addr_lo, 3'b000} +: 8];
  assign w_half     = w_mem_word[{addr_lo[1], 4'b0000} +: 16];

  // Load alignment and sign/zero extension, with misalignment/funct3 checks
  always_comb begin
    w_load_data = '0;
    w_load_err  = 1'b0;
    case (funct3)
      c_f3_lb:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_f3_lbu: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      c_f3_lh: begin
        w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
        w_load_err  = addr_lo[0];
      end
      c_f3_lhu: begin
        w_load_data = {{(XLEN-16){1'b0}}, w_half};
        w_load_err  = addr_lo[0];
      end
      c_f3_lw: begin
        w_load_data = w_mem_word;
        w_load_err  = (addr_lo != 2'b00);
      end
      default: w_load_err = 1'b1;
    endcase
  end

  // An erroring beat carries zero data and never writes the register file
  assign w_err      = !w_sel_hit || (w_is_mem && w_load_err);
  assign w_res_data = w_err ? '0 : (w_is_mem ? w_load_data : w_sel_data);
  assign w_we       = we_in && !w_err && (rd_in != 5'd0);
  assign w_beat     = {w_res_data, rd_in, w_we, w_err};
  assign w_accept   = in_valid && in_ready_q;

  // Skid-buffer next state: skid drains first, so beat order is preserved
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (out_ready) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (!main_valid_q || out_ready) begin
        main_d       = w_beat;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = w_beat;
        skid_valid_d = 1'b1;
      end
    end else if (main_valid_q && out_ready) begin
      main_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers; in_ready is a flop so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q[BEAT_W-1 -: XLEN];
  assign out_rd    = main_q[6:2];
  assign out_we    = main_q[1];
  assign err       = main_q[0];

endmodule
`default_nettype wire

// File: tb/tb_wb_result_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_result_sel
//  Description : Self-checking bench for wb_result_sel: directed cases plus
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_wb_result_sel;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 3;
  localparam int MEM_IDX = 1;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
  } beat_t;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_SRC*XLEN-1:0] src;
  logic [2:0]              funct3;
  logic [1:0]              addr_lo;
  logic [4:0]              rd_in;
  logic                    we_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_data;
  logic [4:0]              out_rd;
  logic                    out_we;
  logic                    err;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t q[$];
  bit    rdy_m    = 1'b0;

  wb_result_sel #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .MEM_IDX(MEM_IDX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .src_data(src), .funct3(funct3), .addr_lo(addr_lo),
    .rd_in(rd_in), .we_in(we_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_we(out_we), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result of one beat, computed from the load rules with plain arithmetic
  function automatic beat_t ref_beat(input int s, input logic [127:0] srcv,
                                     input logic [2:0] f3, input logic [1:0] a,
                                     input logic [4:0] rd, input logic we);
    beat_t       b;
    int unsigned w, byt, half;
    bit          bad;
    b    = '0;
    b.rd = rd;
    bad  = 1'b0;
    if (s >= NUM_SRC) bad = 1'b1;
    else if (s != MEM_IDX) b.data = srcv[s*32 +: 32];
    else begin
      w    = srcv[MEM_IDX*32 +: 32];
      byt  = (w >> (8 * int'(a))) % 256;
      half = (w >> (8 * int'(a))) % 65536;
      case (int'(f3))
        0: b.data = (byt >= 128) ? byt + 32'hFFFF_FF00 : byt;
        4: b.data = byt;
        1: if (a % 2 == 1) bad = 1'b1;
           else b.data = (half >= 32768) ? half + 32'hFFFF_0000 : half;
        5: if (a % 2 == 1) bad = 1'b1; else b.data = half;
        2: if (a != 0) bad = 1'b1; else b.data = w;
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      b.data = '0;
      b.we   = 1'b0;
      b.err  = 1'b1;
    end else begin
      b.we = we && (rd != 5'd0);
    end
    return b;
  endfunction

  // Advance model and DUT by one clock, then compare outputs mid-cycle
  task automatic step();
    bit acc, xfer;
    if (!rst_n) begin
      q.delete();
      rdy_m = 1'b0;
    end else begin
      xfer = (q.size() > 0) && out_ready;
      acc  = in_valid && rdy_m;
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(ref_beat(int'(sel), src, funct3, addr_lo, rd_in, we_in));
      rdy_m = (q.size() < 2);
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("in_ready", 64'(in_ready), 64'(rdy_m));
    check_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check_eq("out_data", 64'(out_data), 64'(q[0].data));
      check_eq("out_rd", 64'(out_rd), 64'(q[0].rd));
      check_eq("out_we", 64'(out_we), 64'(q[0].we));
      check_eq("err", 64'(err), 64'(q[0].err));
    end
  endtask

  task automatic set_beat(input int s, input logic [2:0] f3, input logic [1:0] a,
                          input logic [4:0] rd, input logic we, input logic [31:0] w);
    for (int k = 0; k < NUM_SRC; k++) src[k*32 +: 32] = $urandom;
    if (s < NUM_SRC) src[s*32 +: 32] = w;
    sel      = SEL_W'(s);
    funct3   = f3;
    addr_lo  = a;
    rd_in    = rd;
    we_in    = we;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    set_beat(0, 3'd0, 2'd0, 5'd7, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);

    // Reset held 3 cycles with a beat offered
    repeat (3) step();
    check_eq("rst_data", 64'(out_data), 64'd0);
    check_eq("rst_rd", 64'(out_rd), 64'd0);
    check_eq("rst_we", 64'(out_we), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    check_eq("ready_after_rst", 64'(in_ready), 64'd1);

    // Streaming
    out_ready = 1'b1;
    set_beat(0, 3'd0, 2'd0, 5'd5, 1'b1, 32'h1234_5678);
    step();
    check_eq("stream_data", 64'(out_data), 64'h1234_5678);
    check_eq("stream_rd", 64'(out_rd), 64'd5);
    check_eq("stream_we", 64'(out_we), 64'd1);
    for (int i = 0; i < 4; i++) begin
      set_beat((i % 2 == 0) ? 2 : 3, 3'd0, 2'd0, 5'(i + 1), 1'b1, $urandom);
      step();
      check_eq("b2b_valid", 64'(out_valid), 64'd1);
    end

    // Load extension
    set_beat(MEM_IDX, 3'b000, 2'd3, 5'd4, 1'b1, 32'h80FF_7F01);
    step();
    check_eq("lb", 64'(out_data), 64'hFFFF_FF80);
    set_beat(MEM_IDX, 3'b100, 2'd3, 5'd4, 1'b1, 32'h80FF_7F01);
    step();
    check_eq("lbu", 64'(out_data), 64'h0000_0080);
    set_beat(MEM_IDX, 3'b001, 2'd2, 5'd4, 1'b1, 32'h80FF_7F01);
    step();
    check_eq("lh", 64'(out_data), 64'hFFFF_80FF);
    set_beat(MEM_IDX, 3'b101, 2'd0, 5'd4, 1'b1, 32'h80FF_7F01);
    step();
    check_eq("lhu", 64'(out_data), 64'h0000_7F01);

    // Errors
    set_beat(MEM_IDX, 3'b010, 2'd2, 5'd3, 1'b1, 32'hCAFE_F00D);
    step();
    check_eq("lw_mis_err", 64'(err), 64'd1);
    check_eq("lw_mis_we", 64'(out_we), 64'd0);
    check_eq("lw_mis_data", 64'(out_data), 64'd0);
    set_beat(5, 3'b000, 2'd0, 5'd3, 1'b1, 32'h0);
    step();
    check_eq("sel_oob_err", 64'(err), 64'd1);
    set_beat(MEM_IDX, 3'b011, 2'd0, 5'd3, 1'b1, 32'h1111_2222);
    step();
    check_eq("f3_bad_err", 64'(err), 64'd1);
    set_beat(0, 3'b011, 2'd0, 5'd3, 1'b1, 32'h3333_4444);
    step();
    check_eq("legal_err", 64'(err), 64'd0);
    check_eq("legal_data", 64'(out_data), 64'h3333_4444);
    in_valid = 1'b0;
    step();

    // Backpressure: A, B, C offered with downstream stalled
    out_ready = 1'b0;
    set_beat(0, 3'd0, 2'd0, 5'd1, 1'b1, 32'hAAAA_0001);
    step();
    set_beat(0, 3'd0, 2'd0, 5'd2, 1'b1, 32'hBBBB_0002);
    step();
    check_eq("bp_ready_low", 64'(in_ready), 64'd0);
    set_beat(0, 3'd0, 2'd0, 5'd3, 1'b1, 32'hCCCC_0003);
    step();
    step();
    check_eq("bp_hold_a", 64'(out_data), 64'hAAAA_0001);
    check_eq("bp_hold_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    check_eq("bp_out_b", 64'(out_data), 64'hBBBB_0002);
    check_eq("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    check_eq("bp_out_c", 64'(out_data), 64'hCCCC_0003);
    in_valid = 1'b0;
    step();
    check_eq("bp_drained", 64'(out_valid), 64'd0);

    // Write to x0
    set_beat(0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h5555_AAAA);
    step();
    check_eq("x0_valid", 64'(out_valid), 64'd1);
    check_eq("x0_we", 64'(out_we), 64'd0);
    check_eq("x0_err", 64'(err), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NUM_SRC; k++) src[k*32 +: 32] = $urandom;
      sel       = SEL_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : MEM_IDX);
      funct3    = 3'($urandom_range(0, 7));
      addr_lo   = 2'($urandom_range(0, 3));
      rd_in     = 5'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31));
      we_in     = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("final_empty", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
